// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
//   WB_*   : bit positions inside the 4-bit WBSrc code
//   FWD_*  : E-stage forwarding select encodings
//   hstate_t : hazard FSM state (RUN / MULT / MISS)
package hazard_pkg;
  localparam int WB_MEM  = 0;  // memory load
  localparam int WB_LO   = 1;  // mult LO
  localparam int WB_HI   = 2;  // mult HI
  localparam int WB_LINK = 3;  // PC+8 link

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUMultOutM

  typedef enum logic [1:0] {RUN, MULT, MISS} hstate_t;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: datapath <-> hazard controller signal bundle.
//   master : datapath side (drives tags/enables/events, receives stalls/forwards)
//   slave  : hazard_unit side
interface hazard_unit_if;
  logic [1:0] branchD;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [3:0] WBSrcE, WBSrcM;
  logic       MultStartE, MultDoneE;
  logic       hitM;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushE;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       miss_timeout;

  modport master (
    output branchD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, WBSrcE, WBSrcM,
           MultStartE, MultDoneE, hitM,
    input  stallF, stallD, stallE, stallM, stallW, flushE,
           forwardAD, forwardBD, forwardAE, forwardBE, miss_timeout
  );

  modport slave (
    input  branchD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, WBSrcE, WBSrcM,
           MultStartE, MultDoneE, hitM,
    output stallF, stallD, stallE, stallM, stallW, flushE,
           forwardAD, forwardBD, forwardAE, forwardBE, miss_timeout
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: E-stage forwarding select for one source register tag.
//   tag                  : source register tag in E
//   regWriteM/writeRegM  : M-stage writer
//   regWriteW/writeRegW  : W-stage writer
//   fwdSel               : FWD_M if M writes the tag, else FWD_W if W does, else FWD_RF
// $0 is never forwarded; M is younger so it wins over W.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] tag,
  input  logic       regWriteM,
  input  logic [4:0] writeRegM,
  input  logic       regWriteW,
  input  logic [4:0] writeRegW,
  output logic [1:0] fwdSel
);
  always_comb begin
    fwdSel = FWD_RF;
    if (tag != 5'd0 && regWriteM && tag == writeRegM)      fwdSel = FWD_M;
    else if (tag != 5'd0 && regWriteW && tag == writeRegW) fwdSel = FWD_W;
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: central hazard controller for the 5-stage MIPS pipeline.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_unit_if.slave (tags, enables, WBSrc, mult/cache events in;
//              stall lines, flushE, forwarding selects, miss_timeout out)
// Optional (HAZARD_PERF_EN): perf_stall_cnt / perf_flush_cnt / perf_miss_cnt,
// saturating cycle counters for stallF, flushE and time spent in MISS.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MISS_MAX = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_miss_cnt
`endif
);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

  hstate_t state, stateNxt;
  logic    multBusy, multBusyNxt;
  logic [MW-1:0] missCnt, missCntInc;
  logic    lwStall, branchStall, multStall, missStart;

  // E-stage forwarding: one comparator per source operand (0 = Rs, 1 = Rt)
  logic [1:0][4:0] srcE;
  logic [1:0][1:0] fwdE;
  assign srcE = {hz.RtE, hz.RsE};

  for (genvar i = 0; i < 2; i++) begin : gFwd
    hazard_fwd_sel uFwd (
      .tag      (srcE[i]),
      .regWriteM(hz.RegWriteM),
      .writeRegM(hz.WriteRegM),
      .regWriteW(hz.RegWriteW),
      .writeRegW(hz.WriteRegW),
      .fwdSel   (fwdE[i])
    );
  end

  assign hz.forwardAE = fwdE[0];
  assign hz.forwardBE = fwdE[1];
  assign hz.forwardAD = hz.RsD != 5'd0 && hz.RegWriteM && hz.RsD == hz.WriteRegM;
  assign hz.forwardBD = hz.RtD != 5'd0 && hz.RegWriteM && hz.RtD == hz.WriteRegM;

  // Stall causes
  assign lwStall = hz.WBSrcE[WB_MEM] && hz.WriteRegE != 5'd0 &&
                   (hz.RsD == hz.WriteRegE || hz.RtD == hz.WriteRegE);
  assign branchStall = hz.branchD != 2'b00 &&
    ((hz.RegWriteE      && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
     (hz.WBSrcM[WB_MEM] && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
  // Done is consumed the same cycle, so the dependent op is released on it
  assign multStall = multBusy && (hz.WBSrcE[WB_LO] || hz.WBSrcE[WB_HI]) && !hz.MultDoneE;
  assign missStart = hz.WBSrcM[WB_MEM] && !hz.hitM;

  // A new start in the same cycle as a done keeps the multiplier busy
  assign multBusyNxt = hz.MultStartE || (multBusy && !hz.MultDoneE);
  assign missCntInc  = (missCnt == MISS_LIM) ? missCnt : missCnt + 1'b1;

  // State register plus busy/miss bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      multBusy        <= 1'b0;
      missCnt         <= '0;
      hz.miss_timeout <= 1'b0;
    end else begin
      state    <= stateNxt;
      multBusy <= multBusyNxt;
      if (state == MISS) begin
        if (missCntInc == MISS_LIM) hz.miss_timeout <= 1'b1;
        missCnt <= (stateNxt == MISS) ? missCntInc : '0;
      end else begin
        missCnt <= '0;
      end
    end
  end

  // Next state
  always_comb begin
    stateNxt = state;
    unique case (state)
      RUN:  if (missStart) stateNxt = MISS;
            else if (hz.MultStartE) stateNxt = MULT;
      MULT: if (missStart) stateNxt = MISS;
            else if (!multBusyNxt) stateNxt = RUN;
      MISS: if (hz.hitM) stateNxt = multBusyNxt ? MULT : RUN;
      default: stateNxt = RUN;
    endcase
  end

  // Outputs: a miss freezes F..M while W drains
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.stallW = 1'b0;
    hz.flushE = 1'b0;
    if (state == MISS) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
    end else begin
      hz.stallF = lwStall | branchStall | multStall;
      hz.stallD = lwStall | branchStall | multStall;
      hz.stallE = multStall;
      hz.flushE = (lwStall | branchStall) & !multStall;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_miss_cnt  <= '0;
    end else begin
      if (hz.stallF && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (hz.flushE && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (state == MISS && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 1'b1;
    end
  end
`endif

  // Link bit and non-load M bits do not affect hazards
  logic unusedBits;
  assign unusedBits = ^{hz.WBSrcE[WB_LINK], hz.WBSrcM[3:1], (CNT_W > 0)};
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int MISS_MAX = 8;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_if hz();

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perfStall, perfFlush, perfMiss;
  hazard_unit #(.MISS_MAX(MISS_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .perf_stall_cnt(perfStall), .perf_flush_cnt(perfFlush), .perf_miss_cnt(perfMiss));
`else
  hazard_unit #(.MISS_MAX(MISS_MAX), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract state: are we waiting on a miss, is a multiply outstanding,
  // how long has the miss lasted, and has it ever timed out.
  logic mInMiss  = 1'b0;
  logic mBusy    = 1'b0;
  logic mTimeout = 1'b0;
  int   mMiss    = 0;
  logic [31:0] mStallCnt = '0, mFlushCnt = '0, mMissCnt = '0;

  function automatic logic [1:0] fwdE(input logic [4:0] tag);
    if (tag != 5'd0 && hz.RegWriteM && tag == hz.WriteRegM) return 2'b10;
    if (tag != 5'd0 && hz.RegWriteW && tag == hz.WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  logic eLw, eBr, eMu, eStallF, eStallE, eFlush;
  assign eLw = hz.WBSrcE[0] && hz.WriteRegE != 5'd0 &&
               (hz.RsD == hz.WriteRegE || hz.RtD == hz.WriteRegE);
  assign eBr = hz.branchD != 2'b00 &&
               ((hz.RegWriteE && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                (hz.WBSrcM[0] && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
  assign eMu = mBusy && (hz.WBSrcE[1] || hz.WBSrcE[2]) && !hz.MultDoneE;
  assign eStallF = mInMiss || eLw || eBr || eMu;
  assign eStallE = mInMiss || eMu;
  assign eFlush  = !mInMiss && (eLw || eBr) && !eMu;

  always @(posedge clk) begin
    if (rst) begin
      mInMiss <= 1'b0; mBusy <= 1'b0; mTimeout <= 1'b0; mMiss <= 0;
      mStallCnt <= '0; mFlushCnt <= '0; mMissCnt <= '0;
    end else begin
      if (hz.MultStartE)     mBusy <= 1'b1;
      else if (hz.MultDoneE) mBusy <= 1'b0;
      if (mInMiss) begin
        if (mMiss + 1 >= MISS_MAX) mTimeout <= 1'b1;
        if (hz.hitM) begin mInMiss <= 1'b0; mMiss <= 0; end
        else mMiss <= mMiss + 1;
      end else if (hz.WBSrcM[0] && !hz.hitM) begin
        mInMiss <= 1'b1;
      end
      if (eStallF && mStallCnt != '1) mStallCnt <= mStallCnt + 1;
      if (eFlush  && mFlushCnt != '1) mFlushCnt <= mFlushCnt + 1;
      if (mInMiss && mMissCnt  != '1) mMissCnt  <= mMissCnt + 1;
    end
  end

  // Every cycle: DUT against model
  always @(negedge clk) begin
    chk("m_stallF", 32'(hz.stallF), 32'(eStallF));
    chk("m_stallD", 32'(hz.stallD), 32'(eStallF));
    chk("m_stallE", 32'(hz.stallE), 32'(eStallE));
    chk("m_stallM", 32'(hz.stallM), 32'(mInMiss));
    chk("m_stallW", 32'(hz.stallW), 32'd0);
    chk("m_flushE", 32'(hz.flushE), 32'(eFlush));
    chk("m_fwdAE", 32'(hz.forwardAE), 32'(fwdE(hz.RsE)));
    chk("m_fwdBE", 32'(hz.forwardBE), 32'(fwdE(hz.RtE)));
    chk("m_fwdAD", 32'(hz.forwardAD), 32'(hz.RsD != 0 && hz.RegWriteM && hz.RsD == hz.WriteRegM));
    chk("m_fwdBD", 32'(hz.forwardBD), 32'(hz.RtD != 0 && hz.RegWriteM && hz.RtD == hz.WriteRegM));
    chk("m_timeout", 32'(hz.miss_timeout), 32'(mTimeout));
`ifdef HAZARD_PERF_EN
    chk("m_perfStall", perfStall, mStallCnt);
    chk("m_perfFlush", perfFlush, mFlushCnt);
    chk("m_perfMiss",  perfMiss,  mMissCnt);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.branchD = 2'b00;
    hz.RsD = 5'd0; hz.RtD = 5'd0; hz.RsE = 5'd0; hz.RtE = 5'd0;
    hz.WriteRegE = 5'd0; hz.WriteRegM = 5'd0; hz.WriteRegW = 5'd0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.WBSrcE = 4'd0; hz.WBSrcM = 4'd0;
    hz.MultStartE = 1'b0; hz.MultDoneE = 1'b0;
    hz.hitM = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stallF", 32'(hz.stallF), 32'd0);
    chk("reset_timeout", 32'(hz.miss_timeout), 32'd0);
    step();

    // E forwarding: M wins over W, $0 never forwarded
    hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd3; hz.RsE = 5'd3;
    @(negedge clk); chk("fwdAE_M", 32'(hz.forwardAE), 32'd2);
    step();
    hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd3;
    @(negedge clk); chk("fwdAE_MoverW", 32'(hz.forwardAE), 32'd2);
    step();
    hz.RsE = 5'd0; hz.RtE = 5'd3; hz.RegWriteM = 1'b0;
    @(negedge clk);
    chk("fwdAE_zero", 32'(hz.forwardAE), 32'd0);
    chk("fwdBE_W", 32'(hz.forwardBE), 32'd1);
    step();

    // Load-use: one stall/flush cycle, then lw sits in M with a hit
    clr();
    hz.WBSrcE = 4'b0001; hz.WriteRegE = 5'd5; hz.RtD = 5'd5;
    @(negedge clk);
    chk("lw_stallF", 32'(hz.stallF), 32'd1);
    chk("lw_flushE", 32'(hz.flushE), 32'd1);
    step();
    hz.WBSrcE = 4'd0; hz.WriteRegE = 5'd0;
    hz.WBSrcM = 4'b0001; hz.WriteRegM = 5'd5; hz.RegWriteM = 1'b1; hz.hitM = 1'b1;
    @(negedge clk); chk("lw_release", 32'(hz.stallF), 32'd0);
    step();

    // Branch on an ALU result in E, then forwarded from M
    clr();
    hz.branchD = 2'b01; hz.RsD = 5'd7; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7;
    @(negedge clk);
    chk("br_stallD", 32'(hz.stallD), 32'd1);
    chk("br_flushE", 32'(hz.flushE), 32'd1);
    step();
    hz.RegWriteE = 1'b0; hz.WriteRegE = 5'd0; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd7;
    @(negedge clk);
    chk("br_fwdAD", 32'(hz.forwardAD), 32'd1);
    chk("br_nostall", 32'(hz.stallF), 32'd0);
    step();

    // Multiplier: mflo waits 4 cycles, released on done
    clr();
    hz.MultStartE = 1'b1;
    @(negedge clk); chk("mul_start", 32'(hz.stallE), 32'd0);
    step();
    hz.MultStartE = 1'b0; hz.WBSrcE = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mul_stallE", 32'(hz.stallE), 32'd1);
      chk("mul_stallF", 32'(hz.stallF), 32'd1);
      step();
    end
    hz.MultDoneE = 1'b1;
    @(negedge clk); chk("mul_done", 32'(hz.stallE), 32'd0);
    step();
    clr();

    // Same-cycle start and done keeps the unit busy
    hz.MultStartE = 1'b1; step();
    hz.MultDoneE = 1'b1; step();
    hz.MultStartE = 1'b0; hz.MultDoneE = 1'b0; hz.WBSrcE = 4'b0100;
    @(negedge clk); chk("mul_restart", 32'(hz.stallE), 32'd1);
    step();
    hz.MultDoneE = 1'b1;
    @(negedge clk); chk("mul_restart_done", 32'(hz.stallE), 32'd0);
    step();
    clr();
    step();

    // Cache miss for 10 cycles, MISS_MAX = 8
    hz.WBSrcM = 4'b0001; hz.hitM = 1'b0;
    @(negedge clk); chk("miss_first", 32'(hz.stallM), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 10) hz.hitM = 1'b1;
      @(negedge clk);
      chk("miss_stallM", 32'(hz.stallM), 32'd1);
      chk("miss_stallW", 32'(hz.stallW), 32'd0);
      chk("miss_flushE", 32'(hz.flushE), 32'd0);
      chk("miss_timeout", 32'(hz.miss_timeout), 32'(k >= 9));
    end
    step();
    clr();
    @(negedge clk);
    chk("miss_exit", 32'(hz.stallM), 32'd0);
    chk("miss_sticky", 32'(hz.miss_timeout), 32'd1);
    step();

    // Reset in the middle of a miss (with a multiply outstanding)
    hz.MultStartE = 1'b1; step();
    hz.MultStartE = 1'b0; hz.WBSrcM = 4'b0001; hz.hitM = 1'b0;
    step(); step();
    @(negedge clk); chk("rmiss_stallM", 32'(hz.stallM), 32'd1);
    step();
    rst = 1'b1; clr();
    step();
    @(negedge clk);
    chk("rst_stallF", 32'(hz.stallF), 32'd0);
    chk("rst_stallM", 32'(hz.stallM), 32'd0);
    chk("rst_timeout", 32'(hz.miss_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_perfStall", perfStall, 32'd0);
    chk("rst_perfMiss", perfMiss, 32'd0);
`endif
    step();
    rst = 1'b0;
    hz.WBSrcE = 4'b0010;
    @(negedge clk); chk("rst_multbusy", 32'(hz.stallE), 32'd0);
    step();
    clr();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
